// File: rtl/nanocmos_digital_core.sv
// Chip-side control core: oversampled UART slave with a 16x8 register file,
// static analog configuration outputs, pixel sample enables and a gated clock.
`timescale 1ns/1ps
module nanocmos_digital_core #(
    parameter int NUMREGS       = 16,
    parameter int PIXEL_NUM_ROW = 7,
    parameter int PIXEL_NUM_COL = 16,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     POSI,
    output logic                     PISO,
    input  logic                     SAMPLE_EN,
    output logic [7:0]               opamp_bias1,
    output logic [7:0]               opamp_bias2,
    output logic [7:0]               spare0,
    output logic [7:0]               spare1,
    output logic [7:0]               spare2,
    output logic [7:0]               spare3,
    output logic [PIXEL_NUM_ROW-1:0] row_sample,
    output logic [PIXEL_NUM_COL-1:0] col_sample,
    output logic                     ADC_EN,
    output logic                     CLK_OUT
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(NUMREGS);
    localparam int NB = 18;
    localparam int TB = NB + 2;
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);
    localparam logic [7:0]    NREG_B  = 8'(NUMREGS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    function automatic logic [7:0] reg_default(input int idx);
        case (idx)
            0, 1:    reg_default = 8'h80;
            6:       reg_default = 8'h7F;
            7, 8:    reg_default = 8'hFF;
            9:       reg_default = 8'h03;
            default: reg_default = 8'h00;
        endcase
    endfunction

    // The row mask only has seven storage bits; bit7 always reads back as 0.
    function automatic logic [7:0] wr_mask(input logic [AW-1:0] idx, input logic [7:0] d);
        return (idx == AW'(6)) ? {1'b0, d[6:0]} : d;
    endfunction

    logic [7:0]      r_regs [NUMREGS];
    logic            r_posi_s1, r_posi_s2;
    rx_state_t       r_rx_state, w_rx_next;
    logic [CW-1:0]   r_rx_cnt;
    logic [4:0]      r_rx_bit;
    logic [NB-1:0]   r_rx_shift;
    logic            r_rx_done;
    logic            w_rx_tick, w_rx_sample, w_rx_stop;

    logic            w_wrb, w_in_range, w_wr_en;
    logic [7:0]      w_data, w_addr, w_wr_val, w_rd_val, w_reply_data;
    logic [AW-1:0]   w_idx;
    logic [NB-1:0]   w_reply_payload;

    logic            r_q_vld;
    logic [NB-1:0]   r_q_payload;
    tx_state_t       r_tx_state, w_tx_next;
    logic [CW-1:0]   r_tx_cnt;
    logic [4:0]      r_tx_bit;
    logic [TB-1:0]   r_tx_sh;
    logic            w_tx_load, w_tx_tick;

    logic            r_se_s1, r_se_s2, r_se_s3;
    logic [PIXEL_NUM_ROW-1:0] r_row;
    logic [PIXEL_NUM_COL-1:0] r_col;
    logic            r_adc;
    logic            r_clk_gate;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_posi_s1 <= 1'b1;
            r_posi_s2 <= 1'b1;
        end else begin
            r_posi_s1 <= POSI;
            r_posi_s2 <= r_posi_s1;
        end
    end

    assign w_rx_tick   = (r_rx_cnt == CNT_END);
    assign w_rx_sample = (r_rx_state == RX_DATA) && w_rx_tick;
    assign w_rx_stop   = (r_rx_state == RX_STOP) && w_rx_tick;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    // A start bit is re-checked at mid-bit so short glitches are rejected.
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!r_posi_s2) w_rx_next = RX_START;
            RX_START: if (r_rx_cnt == CNT_MID) w_rx_next = r_posi_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 5'(NB - 1)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            if (r_rx_state == RX_IDLE || r_rx_state != w_rx_next || w_rx_tick)
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_state == RX_START)
                r_rx_bit <= '0;
            else if (w_rx_sample)
                r_rx_bit <= r_rx_bit + 5'd1;
            if (w_rx_sample)
                r_rx_shift <= {r_posi_s2, r_rx_shift[NB-1:1]};
            r_rx_done <= w_rx_stop && r_posi_s2 && (^r_rx_shift);
        end
    end

    // Shift register is stable until the next frame's first data sample.
    assign w_wrb        = r_rx_shift[0];
    assign w_data       = r_rx_shift[8:1];
    assign w_addr       = r_rx_shift[16:9];
    assign w_in_range   = (w_addr < NREG_B);
    assign w_idx        = w_addr[AW-1:0];
    assign w_wr_en      = r_rx_done && !w_wrb && w_in_range;
    assign w_wr_val     = wr_mask(w_idx, w_data);
    assign w_rd_val     = w_in_range ? r_regs[w_idx] : 8'h00;
    assign w_reply_data = w_wr_en ? w_wr_val : w_rd_val;
    assign w_reply_payload = {~^{w_addr, w_reply_data, 1'b1}, w_addr, w_reply_data, 1'b1};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUMREGS; i++)
                r_regs[i] <= reg_default(i);
        end else if (w_wr_en) begin
            r_regs[w_idx] <= w_wr_val;
        end
    end

    assign w_tx_load = (r_tx_state == TX_IDLE) && r_q_vld;
    assign w_tx_tick = (r_tx_cnt == CNT_END);

    // One-deep reply queue; the slot frees in the same cycle the TX takes it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_q_vld     <= 1'b0;
            r_q_payload <= '0;
        end else if (r_rx_done && (!r_q_vld || w_tx_load)) begin
            r_q_vld     <= 1'b1;
            r_q_payload <= w_reply_payload;
        end else if (w_tx_load) begin
            r_q_vld     <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (r_q_vld) w_tx_next = TX_BUSY;
            TX_BUSY: if (w_tx_tick && r_tx_bit == 5'(TB - 1)) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // Idle line is the all-ones shift register, so PISO comes straight off a flop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '1;
        end else if (w_tx_load) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= {1'b1, r_q_payload, 1'b0};
        end else if (r_tx_state == TX_BUSY) begin
            if (w_tx_tick) begin
                r_tx_cnt <= '0;
                r_tx_bit <= r_tx_bit + 5'd1;
                r_tx_sh  <= {1'b1, r_tx_sh[TB-1:1]};
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign PISO = r_tx_sh[0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_se_s1 <= 1'b0;
            r_se_s2 <= 1'b0;
            r_se_s3 <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_adc   <= 1'b0;
        end else begin
            r_se_s1 <= SAMPLE_EN;
            r_se_s2 <= r_se_s1;
            r_se_s3 <= r_se_s2;
            r_row   <= r_se_s2 ? r_regs[6][PIXEL_NUM_ROW-1:0] : '0;
            r_col   <= r_se_s2 ? PIXEL_NUM_COL'({r_regs[8], r_regs[7]}) : '0;
            r_adc   <= r_se_s3 && !r_se_s2 && r_regs[9][1];
        end
    end

    // Enable is captured only while CLK is low so the gated clock never glitches.
    always_latch begin
        if (!CLK) r_clk_gate <= r_regs[9][0];
    end

    assign CLK_OUT     = CLK & r_clk_gate;
    assign row_sample  = r_row;
    assign col_sample  = r_col;
    assign ADC_EN      = r_adc;
    assign opamp_bias1 = r_regs[0];
    assign opamp_bias2 = r_regs[1];
    assign spare0      = r_regs[2];
    assign spare1      = r_regs[3];
    assign spare2      = r_regs[4];
    assign spare3      = r_regs[5];

endmodule

// File: tb/tb_nanocmos_digital_core.sv
// Bench for nanocmos_digital_core: UART frames in, decoded replies and
// analog-side outputs compared against a register-map model.
`timescale 1ns/1ps
module tb_nanocmos_digital_core;

    localparam int OS   = 16;
    localparam int NREG = 16;
    localparam int BITNS = OS * 10;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        POSI = 1'b1;
    logic        SAMPLE_EN = 1'b0;
    logic        PISO, ADC_EN, CLK_OUT;
    logic [7:0]  opamp_bias1, opamp_bias2, spare0, spare1, spare2, spare3;
    logic [6:0]  row_sample;
    logic [15:0] col_sample;

    always #5 CLK = ~CLK;

    nanocmos_digital_core dut (
        .CLK(CLK), .RESET_N(RESET_N), .POSI(POSI), .PISO(PISO), .SAMPLE_EN(SAMPLE_EN),
        .opamp_bias1(opamp_bias1), .opamp_bias2(opamp_bias2),
        .spare0(spare0), .spare1(spare1), .spare2(spare2), .spare3(spare3),
        .row_sample(row_sample), .col_sample(col_sample), .ADC_EN(ADC_EN), .CLK_OUT(CLK_OUT)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m_regs [NREG];
    logic [18:0] rx_q [$];
    logic [18:0] mon_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_regs = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'hFF,
                   8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_bias1"}, opamp_bias1, m_regs[0]);
        check({tag, "_bias2"}, opamp_bias2, m_regs[1]);
        check({tag, "_spare0"}, spare0, m_regs[2]);
        check({tag, "_spare1"}, spare1, m_regs[3]);
        check({tag, "_spare2"}, spare2, m_regs[4]);
        check({tag, "_spare3"}, spare3, m_regs[5]);
    endtask

    task automatic send_frame(input logic [17:0] p);
        @(negedge CLK);
        POSI = 1'b0;
        repeat (OS) @(negedge CLK);
        for (int i = 0; i < 18; i++) begin
            POSI = p[i];
            repeat (OS) @(negedge CLK);
        end
        POSI = 1'b1;
        repeat (OS) @(negedge CLK);
    endtask

    // Decodes PISO into {stop, payload} by sampling at mid-bit.
    initial begin
        @(posedge RESET_N);
        forever begin
            @(negedge PISO);
            #(BITNS / 2);
            if (PISO === 1'b0) begin
                for (int i = 0; i < 19; i++) begin
                    #(BITNS);
                    mon_f[i] = PISO;
                end
                rx_q.push_back(mon_f);
            end
        end
    end

    task automatic txn(input string tag, input bit rd, input int addr,
                       input logic [7:0] data, input bit bad_par);
        logic [17:0] p, exp_p;
        logic [7:0]  a8, exp_data;
        logic [18:0] got;
        int          waited;
        a8 = addr[7:0];
        p = {1'b0, a8, data, rd};
        p[17] = ~^p[16:0];
        if (bad_par) p[17] = ~p[17];
        send_frame(p);
        if (!bad_par) begin
            if (addr < NREG) begin
                if (!rd) m_regs[addr] = (addr == 6) ? (data & 8'h7F) : data;
                exp_data = m_regs[addr];
            end else begin
                exp_data = 8'h00;
            end
            exp_p = {1'b0, a8, exp_data, 1'b1};
            exp_p[17] = ~^exp_p[16:0];
            waited = 0;
            while (rx_q.size() == 0 && waited < 500) begin
                @(negedge CLK);
                waited++;
            end
            check({tag, "_reply_seen"}, 32'(rx_q.size() > 0), 32'd1);
            if (rx_q.size() > 0) begin
                got = rx_q.pop_front();
                check({tag, "_payload"}, 32'(got[17:0]), 32'(exp_p));
                check({tag, "_stop"}, 32'(got[18]), 32'd1);
                check({tag, "_oddpar"}, 32'(^got[17:0]), 32'd1);
            end
        end else begin
            repeat (450) @(negedge CLK);
            check({tag, "_no_reply"}, rx_q.size(), 32'd0);
        end
        check_outputs(tag);
    endtask

    task automatic adc_pulses(output int cnt);
        cnt = 0;
        repeat (12) begin
            @(negedge CLK);
            if (ADC_EN === 1'b1) cnt++;
        end
    endtask

    task automatic check_clk_out(input string tag);
        repeat (3) begin
            @(posedge CLK);
            #2;
            check({tag, "_high_phase"}, 32'(CLK_OUT), 32'(m_regs[9][0]));
            @(negedge CLK);
            #2;
            check({tag, "_low_phase"}, 32'(CLK_OUT), 32'd0);
        end
    endtask

    initial begin
        #(2ms);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_piso", 32'(PISO), 32'd1);
        check("rst_adc", 32'(ADC_EN), 32'd0);
        check("rst_row", 32'(row_sample), 32'd0);
        check("rst_col", 32'(col_sample), 32'd0);
        check_outputs("rst");
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);

        for (int a = 0; a < NREG; a++) txn("rd_default", 1'b1, a, 8'h00, 1'b0);

        txn("wr_reg12", 1'b0, 12, 8'hAD, 1'b0);
        txn("rd_reg12", 1'b1, 12, 8'h00, 1'b0);

        @(negedge CLK);
        POSI = 1'b0;
        #15;
        POSI = 1'b1;
        repeat (400) @(negedge CLK);
        check("runt_no_reply", rx_q.size(), 32'd0);
        check_outputs("runt");
        txn("after_runt", 1'b1, 12, 8'h00, 1'b0);

        txn("bad_parity", 1'b0, 2, 8'h55, 1'b1);

        txn("wr_row", 1'b0, 6, 8'h05, 1'b0);
        txn("wr_coll", 1'b0, 7, 8'h01, 1'b0);
        txn("wr_colh", 1'b0, 8, 8'h00, 1'b0);
        check("row_idle", 32'(row_sample), 32'd0);
        check("col_idle", 32'(col_sample), 32'd0);
        SAMPLE_EN = 1'b1;
        repeat (5) @(negedge CLK);
        check("row_active", 32'(row_sample), 32'h05);
        check("col_active", 32'(col_sample), 32'h0001);
        txn("wr_row_live", 1'b0, 6, 8'hF3, 1'b0);
        check("row_live", 32'(row_sample), 32'(m_regs[6][6:0]));
        check("col_live", 32'(col_sample), 32'({m_regs[8], m_regs[7]}));
        SAMPLE_EN = 1'b0;
        adc_pulses(n);
        check("adc_pulse_count", n, 32'(m_regs[9][1]));
        check("row_after_fall", 32'(row_sample), 32'd0);
        check("col_after_fall", 32'(col_sample), 32'd0);
        check_clk_out("clkout_en");

        txn("wr_ctrl_off", 1'b0, 9, 8'h00, 1'b0);
        check_clk_out("clkout_off");
        SAMPLE_EN = 1'b1;
        repeat (20) @(negedge CLK);
        SAMPLE_EN = 1'b0;
        adc_pulses(n);
        check("adc_disabled", n, 32'(m_regs[9][1]));
        txn("wr_out_of_range", 1'b0, 32, 8'h5A, 1'b0);
        txn("rd_ctrl", 1'b1, 9, 8'h00, 1'b0);

        for (int k = 0; k < 30; k++) begin
            txn("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 19)),
                8'($urandom), ($urandom_range(0, 7) == 0));
        end

        txn("pre_rst_wr", 1'b0, 0, 8'h3C, 1'b0);
        @(negedge CLK);
        POSI = 1'b0;
        repeat (40) @(negedge CLK);
        RESET_N = 1'b0;
        #2;
        model_reset();
        check("midrst_piso", 32'(PISO), 32'd1);
        check_outputs("midrst");
        POSI = 1'b1;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (400) @(negedge CLK);
        check("midrst_no_reply", rx_q.size(), 32'd0);
        txn("post_rst_rd", 1'b1, 0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nanocmos_digital_core.md
Name: nanocmos_digital_core

Overview:
Chip-side digital control core for the nanocmos pixel-array test chip. A 16x-oversampled UART slave receives 18-bit command frames on POSI, reads/writes a 16-entry x 8-bit register file, replies on PISO, and drives static configuration bits plus pixel row/column sample enables to the analog core. The off-chip FPGA UART (uart_tx_fpga/uart_rx_fpga) is the link partner.

Parameters:
NUMREGS, 16, register-file depth
PIXEL_NUM_ROW, 7, row_sample width
PIXEL_NUM_COL, 16, col_sample width
OVERSAMPLE, 16, CLK cycles per UART bit

Ports:
CLK  in  1  system clock, all logic posedge
RESET_N  in  1  asynchronous active-low reset
POSI  in  1  UART serial in (idle high)
PISO  out  1  UART serial out (idle high)
SAMPLE_EN  in  1  pixel sampling window request
opamp_bias1  out  8  reg 0
opamp_bias2  out  8  reg 1
spare0..spare3  out  8 each  regs 2..5
row_sample  out  7  row sample enables
col_sample  out  16  column sample enables
ADC_EN  out  1  ADC start pulse
CLK_OUT  out  1  gated clock to analog core

Behaviour:
- Reset: one clock; reset asynchronous active-low on RESET_N. On reset: PISO=1, ADC_EN=0, row_sample=0, col_sample=0, RX/TX FSMs idle, registers to defaults.
- Frame: start(0), 18 payload bits LSB first, stop(1); each bit OVERSAMPLE CLK cycles. Payload bit0 wrb (0=write,1=read), [8:1] data, [16:9] addr, [17] parity = odd parity over [16:0] (XOR of all 18 bits = 1).
- RX: POSI 2-flop synchronized. IDLE->START on low; re-sample at cycle 8 of bit: still low -> DATA, else back to IDLE (runt start rejected, no side effects). DATA samples at mid-bit (count 8), 18 bits; STOP samples stop bit; stop=0 (framing error) or bad parity -> frame discarded, no write, no reply.
- Write (wrb=0, addr<NUMREGS): reg[addr]<=data in cycle after stop-bit sample; outputs update next cycle. addr>=NUMREGS: ignored.
- Reply: every accepted frame (read or write) produces one TX frame: addr echoed, data=reg[addr] after any write (0 if addr>=NUMREGS), wrb=1, odd parity. TX starts within 2 CLK after RX accept. A frame accepted while TX busy is queued (1-deep); a further one while queue full is dropped.
- Register map / defaults: 0 opamp_bias1 0x80; 1 opamp_bias2 0x80; 2-5 spare0-3 0x00; 6 row mask [6:0] 0x7F (bit7 reads 0); 7 col mask low 0xFF; 8 col mask high 0xFF; 9 control: bit0 CLK_OUT enable (default 1), bit1 ADC enable (default 1), others 0; 10-15 general 0x00.
- Sampling: SAMPLE_EN 2-flop synchronized (s). row_sample = s ? reg6[6:0] : 0; col_sample = s ? {reg8,reg7} : 0 (registered).
- ADC_EN: one-CLK pulse on falling edge of s when reg9[1]=1; otherwise 0.
- CLK_OUT = CLK AND latched reg9[0] (glitch-free latch-based gate, enable updated while CLK low).
- Reset asserted mid-frame: both FSMs abort immediately, PISO returns high, partial frame lost.
- Simultaneous write to reg 6-8 while SAMPLE_EN high: new mask visible the cycle after the write.

Test Plan:
- Reset then read regs 0..15 -> replies with defaults (reg0 0x80, reg6 0x7F, reg9 0x03, reg12 0x00), wrb=1, parity odd.
- Write reg12=0xAD then read reg12 -> write reply and read reply both data 0xAD, addr 0x0C; spare outputs unchanged.
- POSI low 15 ns (runt) then idle -> no reply, no register change; following valid frame still accepted.
- Frame with even parity writing reg2=0x55 -> no reply, spare0 stays 0x00.
- Write reg6=0x05, reg7=0x01, reg8=0x00; SAMPLE_EN high 3 us -> row_sample=7'h05, col_sample=16'h0001 ~2 CLK after rise, both 0 after fall; ADC_EN single 10 ns pulse after fall.
- Write reg9=0x00 -> CLK_OUT held low, no ADC_EN on next SAMPLE_EN fall; write addr 0x20 -> reply data 0x00, no register changed.
